// File: rtl/tx_hop_scheduler.sv
// tx_hop_scheduler
//   Time-division channel scheduler for the transmit path. Steps through a
//   programmable hop table of {source select, DDS phase increment, dwell}.
//   It drives the transmit core's output mux select and the per-channel DDS
//   phase increments. The DAC is muted for GUARD_CYCLES after every hop, so
//   that mux and frequency-shifter transients are blanked.
//
// Ports
//   clock, resetn          sole clock (rising edge), async active-low reset
//   cfg_we/addr/select/    hop-table write port; writes are accepted only
//   phase_inc/dwell        while idle
//   cfg_last_index         last entry of the sequence, latched on start
//   loop_enable            wrap to entry 0 after the last entry, latched on start
//   start, stop            begin a sequence when idle; abort (stop wins)
//   output_select          transmit core mux select
//   dds_phase_inc1..3      per-channel DDS phase increments
//   dac_mute               1 = DAC output zeroed downstream
//   busy                   sequence active (GUARD or DWELL)
//   entry_index            table entry currently applied
//   hop_strobe             one-cycle pulse on every entry load
//   cfg_error              one-cycle pulse after a rejected (busy) write
module tx_hop_scheduler #(
   parameter int TABLE_DEPTH  = 8,
   parameter int DWELL_WIDTH  = 24,
   parameter int GUARD_CYCLES = 4,
   localparam int AW = $clog2(TABLE_DEPTH)
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   cfg_we,
   input  logic [AW-1:0]          cfg_addr,
   input  logic [2:0]             cfg_select,
   input  logic [15:0]            cfg_phase_inc,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic [AW-1:0]          cfg_last_index,
   input  logic                   loop_enable,
   input  logic                   start,
   input  logic                   stop,
   output logic [2:0]             output_select,
   output logic [15:0]            dds_phase_inc1,
   output logic [15:0]            dds_phase_inc2,
   output logic [15:0]            dds_phase_inc3,
   output logic                   dac_mute,
   output logic                   busy,
   output logic [AW-1:0]          entry_index,
   output logic                   hop_strobe,
   output logic                   cfg_error
);

   localparam int GW = $clog2(GUARD_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DWELL} state_t;

   state_t                 state;
   logic [2:0]             sel_tab   [TABLE_DEPTH];
   logic [15:0]            phase_tab [TABLE_DEPTH];
   logic [DWELL_WIDTH-1:0] dwell_tab [TABLE_DEPTH];

   logic [AW-1:0]          last_q;
   logic                   loop_q;
   logic                   muted;
   logic [GW-1:0]          guard_cnt;
   logic [DWELL_WIDTH-1:0] dwell_cnt;

   logic                   load;
   logic [AW-1:0]          load_idx;
   logic [2:0]             ld_sel;
   logic [15:0]            ld_phase;
   logic [DWELL_WIDTH-1:0] ld_dwell;

   // Hop table; writes land only while idle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            sel_tab[i]   <= '0;
            phase_tab[i] <= '0;
            dwell_tab[i] <= '0;
         end
      end else if (cfg_we && state == S_IDLE) begin
         sel_tab[cfg_addr]   <= cfg_select;
         phase_tab[cfg_addr] <= cfg_phase_inc;
         dwell_tab[cfg_addr] <= cfg_dwell;
      end
   end

   // Entry-load decision; stop always suppresses a load.
   always_comb begin
      load     = 1'b0;
      load_idx = '0;
      case (state)
         S_IDLE: begin
            if (start && !stop) load = 1'b1;
         end
         S_DWELL: begin
            if (!stop && dwell_cnt == DWELL_WIDTH'(1)) begin
               if (entry_index != last_q) begin
                  load     = 1'b1;
                  load_idx = entry_index + AW'(1);
               end else if (loop_q) begin
                  load = 1'b1;
               end
            end
         end
         default: ;
      endcase
      ld_sel   = sel_tab[load_idx];
      ld_phase = phase_tab[load_idx];
      ld_dwell = dwell_tab[load_idx];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         output_select  <= 3'd1;
         dds_phase_inc1 <= '0;
         dds_phase_inc2 <= '0;
         dds_phase_inc3 <= '0;
         dac_mute       <= 1'b1;
         busy           <= 1'b0;
         entry_index    <= '0;
         hop_strobe     <= 1'b0;
         cfg_error      <= 1'b0;
         last_q         <= '0;
         loop_q         <= 1'b0;
         muted          <= 1'b1;
         guard_cnt      <= '0;
         dwell_cnt      <= '0;
      end else begin
         hop_strobe <= load;
         cfg_error  <= cfg_we && (state != S_IDLE);
         if (load) begin
            state       <= S_GUARD;
            entry_index <= load_idx;
            dac_mute    <= 1'b1;
            busy        <= 1'b1;
            guard_cnt   <= GW'(GUARD_CYCLES - 1);
            dwell_cnt   <= (ld_dwell == '0) ? DWELL_WIDTH'(1) : ld_dwell;
            muted       <= !(ld_sel inside {3'd1, 3'd2, 3'd3});
            if (state == S_IDLE) begin
               last_q <= cfg_last_index;
               loop_q <= loop_enable;
            end
            // A muted entry leaves select and every increment untouched.
            case (ld_sel)
               3'd1: begin output_select <= 3'd1; dds_phase_inc1 <= ld_phase; end
               3'd2: begin output_select <= 3'd2; dds_phase_inc2 <= ld_phase; end
               3'd3: begin output_select <= 3'd3; dds_phase_inc3 <= ld_phase; end
               default: ;
            endcase
         end else begin
            case (state)
               S_IDLE: ;
               S_GUARD: begin
                  if (stop) begin
                     state    <= S_IDLE;
                     dac_mute <= 1'b1;
                     busy     <= 1'b0;
                  end else if (guard_cnt == '0) begin
                     state    <= S_DWELL;
                     dac_mute <= muted;
                  end else begin
                     guard_cnt <= guard_cnt - GW'(1);
                  end
               end
               S_DWELL: begin
                  // No load here means either stop or a non-looping end.
                  if (stop || dwell_cnt == DWELL_WIDTH'(1)) begin
                     state    <= S_IDLE;
                     dac_mute <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
